// File: rtl/mem_responder.sv
// Request/response memory responder: services reads/writes from a register array and returns
// one in-order response per accepted request through a registered FIFO. Optional parity via MEM_RESPONDER_PARITY_EN.
module mem_responder #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int RSP_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_write,
    input  logic [ADDR_W-1:0]              req_addr,
    input  logic [DATA_W-1:0]              req_wdata,
`ifdef MEM_RESPONDER_PARITY_EN
    input  logic                           req_parity,
    output logic                           rsp_parity,
`endif
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic                           rsp_write,
    output logic [ADDR_W-1:0]              rsp_addr,
    output logic [DATA_W-1:0]              rsp_rdata,
    output logic [$clog2(RSP_DEPTH+1)-1:0] rsp_count
);
    localparam int PTR_W     = $clog2(RSP_DEPTH);
    localparam int CNT_W     = $clog2(RSP_DEPTH+1);
    localparam int MEM_WORDS = 2**ADDR_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RSP_DEPTH);

    typedef enum logic [1:0] {ST_EMPTY, ST_HOLD, ST_FULL} state_t;

    logic [DATA_W-1:0] mem_q [MEM_WORDS];
    logic              fifo_write_q [RSP_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_q  [RSP_DEPTH];
    logic [DATA_W-1:0] fifo_data_q  [RSP_DEPTH];
`ifdef MEM_RESPONDER_PARITY_EN
    logic              fifo_par_q   [RSP_DEPTH];
    logic              push_parity;
`endif

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic             rsp_valid_q;
    logic             req_fire, rsp_fire;
    logic [DATA_W-1:0] push_data;

    always_comb begin
        req_ready = (count_q < FULL_CNT);
        req_fire  = req_valid & req_ready;
        rsp_fire  = rsp_valid_q & rsp_ready;
        // Reads capture storage as it stood before this edge.
        push_data = req_write ? req_wdata : mem_q[req_addr];
`ifdef MEM_RESPONDER_PARITY_EN
        push_parity = (^push_data) ^ (req_write & (req_parity != (^req_wdata)));
`endif
        wr_ptr_d = req_fire ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rsp_fire ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (req_fire && !rsp_fire)
            count_d = count_q + CNT_W'(1);
        else if (!req_fire && rsp_fire)
            count_d = count_q - CNT_W'(1);

        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (req_fire) state_d = (count_d == FULL_CNT) ? ST_FULL : ST_HOLD;
            ST_HOLD: begin
                if (count_d == FULL_CNT)   state_d = ST_FULL;
                else if (count_d == '0)    state_d = ST_EMPTY;
            end
            ST_FULL:  if (rsp_fire) state_d = ST_HOLD;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
            for (int j = 0; j < RSP_DEPTH; j++) begin
                fifo_write_q[j] <= 1'b0;
                fifo_addr_q[j]  <= '0;
                fifo_data_q[j]  <= '0;
`ifdef MEM_RESPONDER_PARITY_EN
                fifo_par_q[j]   <= 1'b0;
`endif
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_EMPTY;
            rsp_valid_q <= 1'b0;
        end else begin
            if (req_fire) begin
                if (req_write) mem_q[req_addr] <= req_wdata;
                fifo_write_q[wr_ptr_q] <= req_write;
                fifo_addr_q[wr_ptr_q]  <= req_addr;
                fifo_data_q[wr_ptr_q]  <= push_data;
`ifdef MEM_RESPONDER_PARITY_EN
                fifo_par_q[wr_ptr_q]   <= push_parity;
`endif
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            rsp_valid_q <= (state_d != ST_EMPTY);
        end
    end

    // Head entry stays put until popped, so outputs are stable under backpressure.
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = fifo_write_q[rd_ptr_q];
    assign rsp_addr  = fifo_addr_q[rd_ptr_q];
    assign rsp_rdata = fifo_data_q[rd_ptr_q];
    assign rsp_count = count_q;
`ifdef MEM_RESPONDER_PARITY_EN
    assign rsp_parity = fifo_par_q[rd_ptr_q];
`endif
endmodule
